reg_write_port_arbiter: RTL



---
 rtl/reg_write_port_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/reg_write_port_arbiter.sv
// reg_write_port_arbiter
//   Shares the single register-file write port between the write-back stage
//   and the multi-cycle (mul/div) unit. Write-back always wins; multi-cycle
//   results wait in a small in-order FIFO and drain on idle write-back cycles,
//   or bypass straight to the port when the FIFO is empty and write-back is idle.
//   A starvation FSM raises stall_o when queued results have lost the port
//   STARVE_LIMIT times in a row.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   wb_valid_i/_write_en_i   write-back request (both high = request)
//   wb_addr_i, wb_data_i     write-back destination/data
//   mc_valid_i/_addr_i/_data_i  multi-cycle result presented
//   mc_ready_o               multi-cycle result accepted this cycle
//   query_addr_i             decode-stage source register for hazard lookup
//   pending_hit_o            query matches a queued or incoming mc destination
//   stall_o                  registered bubble request to the hazard unit
//   rf_write_en_o/_addr_o/_data_o  register-file write port
module reg_write_port_arbiter #(
    parameter int WORD         = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_valid_i,
    input  logic                  wb_write_en_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WORD-1:0]       wb_data_i,
    input  logic                  mc_valid_i,
    input  logic [ADDR_WIDTH-1:0] mc_addr_i,
    input  logic [WORD-1:0]       mc_data_i,
    output logic                  mc_ready_o,
    input  logic [ADDR_WIDTH-1:0] query_addr_i,
    output logic                  pending_hit_o,
    output logic                  stall_o,
    output logic                  rf_write_en_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [WORD-1:0]       rf_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned DEPTH_U = DEPTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;

    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [WORD-1:0]       data_mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [1:0]    state_q, state_d;
    logic          stall_q;

    logic wb_req;
    logic fifo_nonempty;
    logic pop;
    logic bypass;
    logic push;
    logic hit;
    logic [PW-1:0] slot_off;

    // Grant selection and FIFO control
    always_comb begin
        wb_req        = wb_valid_i & wb_write_en_i;
        fifo_nonempty = (count_q != '0);
        pop           = !wb_req && fifo_nonempty;
        bypass        = !wb_req && !fifo_nonempty && mc_valid_i;
        // Readiness deliberately ignores a same-cycle pop.
        mc_ready_o    = (count_q < DEPTH_C);
        push          = mc_valid_i && mc_ready_o && !bypass;

        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // Write-port mux
    always_comb begin
        rf_write_en_o = !rst_i && (wb_req || fifo_nonempty || mc_valid_i);
        if (wb_req) begin
            rf_addr_o = wb_addr_i;
            rf_data_o = wb_data_i;
        end else if (fifo_nonempty) begin
            rf_addr_o = addr_mem_q[rd_ptr_q];
            rf_data_o = data_mem_q[rd_ptr_q];
        end else begin
            rf_addr_o = mc_addr_i;
            rf_data_o = mc_data_i;
        end
    end

    // Hazard lookup: a slot is live when its distance from the read pointer
    // is below the occupancy count.
    always_comb begin
        hit      = mc_valid_i && (mc_addr_i == query_addr_i);
        slot_off = '0;
        for (int unsigned i = 0; i < DEPTH_U; i++) begin
            slot_off = PW'(i) - rd_ptr_q;
            if (({1'b0, slot_off} < count_q) && (addr_mem_q[i] == query_addr_i)) begin
                hit = 1'b1;
            end
        end
        pending_hit_o = hit;
    end

    // Starvation FSM
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ST_IDLE: begin
                starve_d = '0;
                if (count_d != '0) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pop) begin
                    starve_d = '0;
                end else if (wb_req && fifo_nonempty && (starve_q != LIMIT_C)) begin
                    starve_d = starve_q + 1'b1;
                end
                if (count_d == '0) begin
                    state_d  = ST_IDLE;
                    starve_d = '0;
                end else if (starve_d >= LIMIT_C) begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                if (pop) begin
                    starve_d = '0;
                    state_d  = (count_d == '0) ? ST_IDLE : ST_WAIT;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                starve_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            state_q  <= ST_IDLE;
            stall_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            state_q  <= state_d;
            stall_q  <= (state_d == ST_FORCE);
        end
    end

    // Storage needs no reset: occupancy masks stale slots.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= mc_addr_i;
            data_mem_q[wr_ptr_q] <= mc_data_i;
        end
    end

    assign stall_o = stall_q;

endmodule
